// File: rtl/mips_pipe_pkg.sv
// Shared constants and fetch-action encoding for the MIPS pipeline front end.
package mips_pipe_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam int unsigned PC_INC           = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [1:0] ACT_REDIRECT = 2'd0;
  localparam logic [1:0] ACT_HOLD     = 2'd1;
  localparam logic [1:0] ACT_BUBBLE   = 2'd2;
  localparam logic [1:0] ACT_ADVANCE  = 2'd3;

  // Redirect beats a load-use hold, which beats a branch/jump bubble.
  function automatic logic [1:0] sel_action(input logic redirect, input logic lw,
                                            input logic jb);
    if (redirect)  return ACT_REDIRECT;
    else if (lw)   return ACT_HOLD;
    else if (jb)   return ACT_BUBBLE;
    else           return ACT_ADVANCE;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect inputs, instruction memory and IF/ID outputs.
interface fetch_if #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                   stall_JB;
  logic                   stall_lw;
  logic                   redirect_valid;
  logic [PC_WIDTH-1:0]    redirect_pc;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic [INSTR_WIDTH-1:0] if_id_instr;
  logic [PC_WIDTH-1:0]    if_id_pc4;
  logic                   if_id_valid;

  modport master (
    input  stall_JB, stall_lw, redirect_valid, redirect_pc, imem_rdata,
    output imem_addr, if_id_instr, if_id_pc4, if_id_valid
  );

  modport slave (
    output stall_JB, stall_lw, redirect_valid, redirect_pc, imem_rdata,
    input  imem_addr, if_id_instr, if_id_pc4, if_id_valid
  );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: bubble inserts a NOP and keeps pc4, hold freezes, load captures.
module if_id_reg
  import mips_pipe_pkg::*;
#(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   load,
  input  logic                   hold,
  input  logic                   bubble,
  input  logic [INSTR_WIDTH-1:0] instr_d,
  input  logic [PC_WIDTH-1:0]    pc4_d,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    pc4,
  output logic                   valid
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      instr <= INSTR_WIDTH'(NOP_INSTR);
      pc4   <= '0;
      valid <= 1'b0;
    end else if (bubble) begin
      instr <= INSTR_WIDTH'(NOP_INSTR);
      valid <= 1'b0;
    end else if (load && !hold) begin
      instr <= instr_d;
      pc4   <= pc4_d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, action priority and IF/ID register.
// Optional perf counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage
  import mips_pipe_pkg::*;
#(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic        CLK,
  input  logic        RST,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_lw_stall_cnt,
  output logic [31:0] perf_bubble_cnt,
`endif
  fetch_if.master     bus
);

  logic [PC_WIDTH-1:0]    pc;
  logic [PC_WIDTH-1:0]    pc_next4;
  logic [1:0]             act;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [PC_WIDTH-1:0]    pc4_q;
  logic                   valid_q;
  logic                   unused_redirect_lo;

  assign pc_next4           = pc + PC_WIDTH'(PC_INC);
  assign act                = sel_action(bus.redirect_valid, bus.stall_lw, bus.stall_JB);
  assign unused_redirect_lo = ^bus.redirect_pc[1:0];

  // Wrap-around of the PC at the top of the address space is intentional.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc <= RESET_PC;
    end else begin
      case (act)
        ACT_REDIRECT: pc <= {bus.redirect_pc[PC_WIDTH-1:2], 2'b00};
        ACT_ADVANCE:  pc <= pc_next4;
        default:      pc <= pc;
      endcase
    end
  end

  if_id_reg #(
    .PC_WIDTH    (PC_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_if_id (
    .CLK     (CLK),
    .RST     (RST),
    .load    (act == ACT_ADVANCE),
    .hold    (act == ACT_HOLD),
    .bubble  ((act == ACT_REDIRECT) || (act == ACT_BUBBLE)),
    .instr_d (bus.imem_rdata),
    .pc4_d   (pc_next4),
    .instr   (instr_q),
    .pc4     (pc4_q),
    .valid   (valid_q)
  );

  assign bus.imem_addr   = pc;
  assign bus.if_id_instr = instr_q;
  assign bus.if_id_pc4   = pc4_q;
  assign bus.if_id_valid = valid_q;

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      perf_lw_stall_cnt <= '0;
      perf_bubble_cnt   <= '0;
    end else begin
      if (act == ACT_HOLD)
        perf_lw_stall_cnt <= sat_inc(perf_lw_stall_cnt);
      if ((act == ACT_REDIRECT) || (act == ACT_BUBBLE))
        perf_bubble_cnt <= sat_inc(perf_bubble_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage (FETCH_PERF_CNT_EN optional).
module tb_fetch_stage;
  import mips_pipe_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fetch_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_lw_stall_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  fetch_stage #(
    .PC_WIDTH    (32),
    .INSTR_WIDTH (32),
    .RESET_PC    (32'h0000_0000)
  ) dut (
    .CLK               (CLK),
    .RST               (RST),
`ifdef FETCH_PERF_CNT_EN
    .perf_lw_stall_cnt (perf_lw_stall_cnt),
    .perf_bubble_cnt   (perf_bubble_cnt),
`endif
    .bus               (bus.master)
  );

  always #5 CLK = ~CLK;

  // Instruction memory image: word at address A reads 0xC0DE_<A[15:0]>.
  assign bus.imem_rdata = {16'hC0DE, bus.imem_addr[15:0]};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rv, input logic [31:0] rpc, input logic lw, input logic jb);
    @(negedge CLK);
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.stall_lw       = lw;
    bus.stall_JB       = jb;
  endtask

  task automatic edge_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc,
                            input logic [31:0] instr, input logic [31:0] pc4,
                            input logic valid);
    check({tag, "_pc"},    bus.imem_addr,         pc);
    check({tag, "_instr"}, bus.if_id_instr,       instr);
    check({tag, "_pc4"},   bus.if_id_pc4,         pc4);
    check({tag, "_valid"}, {31'd0, bus.if_id_valid}, {31'd0, valid});
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.stall_lw       = 1'b0;
    bus.stall_JB       = 1'b0;
    #12;
    check_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge CLK);
    RST = 1'b0;

    // Free run from RESET_PC
    edge_step(); check_ifid("run1", 32'h4, 32'hC0DE_0000, 32'h4, 1'b1);
    edge_step(); check_ifid("run2", 32'h8, 32'hC0DE_0004, 32'h8, 1'b1);
    edge_step(); check_ifid("run3", 32'hC, 32'hC0DE_0008, 32'hC, 1'b1);
    edge_step(); check_ifid("run4", 32'h10, 32'hC0DE_000C, 32'h10, 1'b1);

    // Load-use hold at PC=0x10
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    edge_step(); check_ifid("lw_hold", 32'h10, 32'hC0DE_000C, 32'h10, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    edge_step(); check_ifid("lw_release", 32'h14, 32'hC0DE_0010, 32'h14, 1'b1);
    edge_step(); edge_step(); edge_step();
    check_ifid("run_to_20", 32'h20, 32'hC0DE_001C, 32'h20, 1'b1);

    // Two branch/jump bubbles, then redirect to 0x103 (aligned to 0x100)
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    edge_step(); check_ifid("jb1", 32'h20, 32'h0, 32'h20, 1'b0);
    edge_step(); check_ifid("jb2", 32'h20, 32'h0, 32'h20, 1'b0);
    drive(1'b1, 32'h103, 1'b0, 1'b0);
    edge_step(); check_ifid("redir", 32'h100, 32'h0, 32'h20, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    edge_step(); check_ifid("redir_tgt", 32'h104, 32'hC0DE_0100, 32'h104, 1'b1);

    // Redirect wins over both stalls
    drive(1'b1, 32'h40, 1'b1, 1'b1);
    edge_step(); check_ifid("prio", 32'h40, 32'h0, 32'h104, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    edge_step(); check_ifid("prio_tgt", 32'h44, 32'hC0DE_0040, 32'h44, 1'b1);

    // PC wrap at top of address space
    drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    edge_step(); check_ifid("wrap_redir", 32'hFFFF_FFFC, 32'h0, 32'h44, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    edge_step(); check_ifid("wrap", 32'h0, 32'hC0DE_FFFC, 32'h0, 1'b1);
    edge_step(); check_ifid("after_wrap", 32'h4, 32'hC0DE_0000, 32'h4, 1'b1);

    // Redirect then stall_JB, then asynchronous reset mid-stall
    drive(1'b1, 32'h200, 1'b0, 1'b0);
    edge_step(); check_ifid("pre_rst_redir", 32'h200, 32'h0, 32'h4, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    edge_step(); check_ifid("pre_rst_jb", 32'h200, 32'h0, 32'h4, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    check("perf_lw_pre",  perf_lw_stall_cnt, 32'd1);
    check("perf_bub_pre", perf_bubble_cnt,   32'd7);
`endif
    #2;
    RST = 1'b1;
    #1;
    check_ifid("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    check("perf_lw_rst",  perf_lw_stall_cnt, 32'd0);
    check("perf_bub_rst", perf_bubble_cnt,   32'd0);
`endif
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    RST = 1'b0;
    edge_step(); check_ifid("post_rst", 32'h4, 32'hC0DE_0000, 32'h4, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
